instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, byte address loaded into the PC on reset.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: stall  input  1  hold the PC and the IF/ID register this cycle.
REQ-005: flush  input  1  load a bubble into the IF/ID register this cycle.
REQ-006: redirect  input  1  a branch or jump was taken; load redirect_pc into the PC.
REQ-007: redirect_pc  input  32  branch or jump target byte address.
REQ-008: imem_addr  output  10  word address to the instruction memory, equal to pc[11:2].
REQ-009: imem_data  input  32  instruction word returned combinationally by the instruction memory in the same cycle.
REQ-010: pc  output  32  current fetch PC as a byte address.
REQ-011: if_id_instr  output  32  registered instruction passed to the decode stage.
REQ-012: if_id_pc4  output  32  registered PC+4 of that instruction.
REQ-013: if_id_valid  output  1  high when the IF/ID register holds a real instruction.
REQ-014: addr_err  output  1  sticky fetch-address error flag.
REQ-015: fetch_count  output  32  count of valid instructions delivered to IF/ID.

Function
REQ-016: imem_addr SHALL be pc[11:2] combinationally, with no register between pc and imem_addr.
REQ-017: Update priority on each edge SHALL be: rst, then redirect, then stall, then flush, then normal.
REQ-018: Normal operation (no rst, redirect, stall or flush) SHALL apply all of the following:
- pc <= pc+4
- if_id_instr <= imem_data
- if_id_pc4 <= pc+4
- if_id_valid <= 1
- fetch_count <= fetch_count+1
REQ-019: A bubble SHALL set if_id_instr=0 (NOP), if_id_pc4=0 and if_id_valid=0, and SHALL leave fetch_count unchanged.
REQ-020: On redirect, the block SHALL set pc <= {redirect_pc[31:2],2'b00} and load a bubble into IF/ID, regardless of stall and flush.
REQ-021: On stall without redirect, the block SHALL hold pc; IF/ID SHALL also hold unless flush is high, in which case IF/ID takes a bubble.
REQ-022: On flush without stall or redirect, pc SHALL advance by 4 and IF/ID SHALL take a bubble.
REQ-023: PC arithmetic SHALL be 32-bit unsigned and wrap modulo 2^32.
REQ-024: fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-025: addr_err SHALL be set to 1 on the edge where either of the following occurs:
- a redirect with redirect_pc[1:0]!=0 is accepted
- the PC is loaded with a value where pc[31:12]!=0 (outside the 4 KB instruction space)
REQ-026: Once set, addr_err SHALL stay at 1 until rst; fetch SHALL continue and imem_addr SHALL still be pc[11:2] (the address aliases).
REQ-027: Latency SHALL be one cycle: the instruction at pc appears on if_id_instr after the next rising edge.

Reset
REQ-028: While rst is high at a rising edge, the block SHALL set:
- pc=RESET_PC
- if_id_instr=0
- if_id_pc4=0
- if_id_valid=0
- addr_err=0
- fetch_count=0
REQ-029: rst SHALL override redirect, stall and flush when they occur in the same cycle.
REQ-030: rst asserted mid-operation SHALL discard in-flight IF/ID contents, with no partial update.

Verification
REQ-031: Reset release, then two normal cycles:
- Stimulus: hold rst for 2 cycles and release; imem returns 32'h0022_1820 at address 0 and 32'h0022_2022 at address 1.
- After edge 1: if_id_instr=32'h0022_1820, if_id_pc4=4, if_id_valid=1, pc=4, imem_addr=1.
- After edge 2: if_id_instr=32'h0022_2022, if_id_pc4=8, fetch_count=2.
REQ-032: Stall hold:
- Stimulus: at pc=8, hold stall for 3 cycles.
- Response: pc, imem_addr=2, the IF/ID outputs and fetch_count stay unchanged throughout; normal advance resumes the cycle after stall drops.
REQ-033: Redirect:
- Stimulus: at pc=32'h0C, assert redirect with redirect_pc=32'h14, with stall also high.
- After the edge: pc=32'h14, imem_addr=5, if_id_valid=0, if_id_instr=0.
- After the next normal edge: if_id_valid=1, if_id_pc4=32'h18.
REQ-034: Flush with stall:
- Stimulus: at pc=32'h10, assert flush and stall together.
- Response: pc stays 32'h10, if_id_valid=0, fetch_count unchanged.
REQ-035: Misaligned redirect:
- Stimulus: redirect_pc=32'h16.
- Response: pc=32'h14, addr_err=1; addr_err stays 1 through 10 later normal cycles and clears only after rst.
REQ-036: Address range:
- Stimulus: redirect to 32'hFFC, then one normal cycle.
- Response: pc=32'h1000, imem_addr=0, addr_err=1, if_id_pc4=32'h1000.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, combinational instruction-memory addressing
// and the IF/ID pipeline register with stall, flush and redirect handling.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        addr_err,
    output logic [31:0] fetch_count
);

    // Instruction space is 4 KB; any PC above it aliases into imem and is flagged.
    function automatic logic out_of_range(input logic [31:0] addr);
        return (addr[31:12] != 20'h0_0000);
    endfunction

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] pc4_r;
    logic        valid_r;
    logic        err_r;
    logic [31:0] count_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;
    logic [31:0] pc_nxt_s;
    logic [31:0] instr_nxt_s;
    logic [31:0] pc4_nxt_s;
    logic        valid_nxt_s;
    logic        err_nxt_s;
    logic [31:0] count_nxt_s;

    // Next-state selection, priority redirect > stall > flush > normal fetch
    always_comb begin
        pc_plus4_s  = pc_r + 32'd4;
        target_s    = {redirect_pc[31:2], 2'b00};
        pc_nxt_s    = pc_r;
        instr_nxt_s = instr_r;
        pc4_nxt_s   = pc4_r;
        valid_nxt_s = valid_r;
        err_nxt_s   = err_r;
        count_nxt_s = count_r;
        if (redirect) begin
            pc_nxt_s    = target_s;
            instr_nxt_s = 32'h0000_0000;
            pc4_nxt_s   = 32'h0000_0000;
            valid_nxt_s = 1'b0;
            err_nxt_s   = err_r | (redirect_pc[1:0] != 2'b00) | out_of_range(target_s);
        end else if (stall) begin
            if (flush) begin
                instr_nxt_s = 32'h0000_0000;
                pc4_nxt_s   = 32'h0000_0000;
                valid_nxt_s = 1'b0;
            end else begin
                instr_nxt_s = instr_r;
                pc4_nxt_s   = pc4_r;
                valid_nxt_s = valid_r;
            end
        end else if (flush) begin
            pc_nxt_s    = pc_plus4_s;
            instr_nxt_s = 32'h0000_0000;
            pc4_nxt_s   = 32'h0000_0000;
            valid_nxt_s = 1'b0;
            err_nxt_s   = err_r | out_of_range(pc_plus4_s);
        end else begin
            pc_nxt_s    = pc_plus4_s;
            instr_nxt_s = imem_data;
            pc4_nxt_s   = pc_plus4_s;
            valid_nxt_s = 1'b1;
            count_nxt_s = count_r + 32'd1;
            err_nxt_s   = err_r | out_of_range(pc_plus4_s);
        end
    end

    // State registers with synchronous reset that discards in-flight IF/ID contents
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            pc4_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            count_r <= 32'h0000_0000;
        end else begin
            pc_r    <= pc_nxt_s;
            instr_r <= instr_nxt_s;
            pc4_r   <= pc4_nxt_s;
            valid_r <= valid_nxt_s;
            err_r   <= err_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    assign imem_addr   = pc_r[11:2];
    assign pc          = pc_r;
    assign if_id_instr = instr_r;
    assign if_id_pc4   = pc4_r;
    assign if_id_valid = valid_r;
    assign addr_err    = err_r;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a reference model pushes expected state
// per edge into a scoreboard, and scenario tasks check the directed values inline.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        addr_err;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] count;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_err;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .addr_err(addr_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    // Scoreboard monitor: compare the DUT state against each queued model prediction
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks = checks + 7;
            if (pc !== mon_e.pc) begin errors++; $display("FAIL sb_pc: got %h expected %h", pc, mon_e.pc); end
            if (imem_addr !== mon_e.pc[11:2]) begin errors++; $display("FAIL sb_imem_addr: got %h expected %h", imem_addr, mon_e.pc[11:2]); end
            if (if_id_instr !== mon_e.instr) begin errors++; $display("FAIL sb_instr: got %h expected %h", if_id_instr, mon_e.instr); end
            if (if_id_pc4 !== mon_e.pc4) begin errors++; $display("FAIL sb_pc4: got %h expected %h", if_id_pc4, mon_e.pc4); end
            if (if_id_valid !== mon_e.valid) begin errors++; $display("FAIL sb_valid: got %b expected %b", if_id_valid, mon_e.valid); end
            if (fetch_count !== mon_e.count) begin errors++; $display("FAIL sb_count: got %0d expected %0d", fetch_count, mon_e.count); end
            if (addr_err !== mon_e.err) begin errors++; $display("FAIL sb_addr_err: got %b expected %b", addr_err, mon_e.err); end
        end
    end

    // Drive one cycle, predict the post-edge state, and queue the prediction
    task automatic cycle(input logic r, input logic s, input logic f, input logic rd, input logic [31:0] rpc);
        exp_t e;
        rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_count = 32'h0;
        end else if (rd) begin
            m_pc = {rpc[31:2], 2'b00};
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            if (rpc[1:0] != 2'b00 || m_pc[31:12] != 20'h0) m_err = 1'b1;
        end else if (s) begin
            if (f) begin m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; end
        end else if (f) begin
            m_pc = m_pc + 32'd4;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            if (m_pc[31:12] != 20'h0) m_err = 1'b1;
        end else begin
            m_instr = mem[m_pc[11:2]];
            m_pc = m_pc + 32'd4;
            m_pc4 = m_pc; m_valid = 1'b1; m_count = m_count + 32'd1;
            if (m_pc[31:12] != 20'h0) m_err = 1'b1;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.count = m_count; e.valid = m_valid; e.err = m_err;
        @(posedge clk);
        #1;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0042);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
        checks = checks + 5;
        if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
        if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", if_id_instr); end
        if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
        if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
        if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", addr_err); end
    endtask

    task automatic test_normal();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks = checks + 5;
        if (if_id_instr !== 32'h0022_1820) begin errors++; $display("FAIL normal1_instr: got %h expected 00221820", if_id_instr); end
        if (if_id_pc4 !== 32'd4) begin errors++; $display("FAIL normal1_pc4: got %h expected 4", if_id_pc4); end
        if (if_id_valid !== 1'b1) begin errors++; $display("FAIL normal1_valid: got %b expected 1", if_id_valid); end
        if (pc !== 32'd4) begin errors++; $display("FAIL normal1_pc: got %h expected 4", pc); end
        if (imem_addr !== 10'd1) begin errors++; $display("FAIL normal1_imem_addr: got %h expected 1", imem_addr); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks = checks + 3;
        if (if_id_instr !== 32'h0022_2022) begin errors++; $display("FAIL normal2_instr: got %h expected 00222022", if_id_instr); end
        if (if_id_pc4 !== 32'd8) begin errors++; $display("FAIL normal2_pc4: got %h expected 8", if_id_pc4); end
        if (fetch_count !== 32'd2) begin errors++; $display("FAIL normal2_count: got %0d expected 2", fetch_count); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            checks = checks + 4;
            if (pc !== 32'd8) begin errors++; $display("FAIL stall_pc: got %h expected 8", pc); end
            if (imem_addr !== 10'd2) begin errors++; $display("FAIL stall_imem_addr: got %h expected 2", imem_addr); end
            if (if_id_instr !== 32'h0022_2022) begin errors++; $display("FAIL stall_instr: got %h expected 00222022", if_id_instr); end
            if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count: got %0d expected 2", fetch_count); end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks = checks + 2;
        if (pc !== 32'h0C) begin errors++; $display("FAIL stall_resume_pc: got %h expected c", pc); end
        if (if_id_pc4 !== 32'h0C) begin errors++; $display("FAIL stall_resume_pc4: got %h expected c", if_id_pc4); end
    endtask

    task automatic test_redirect();
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0014);
        checks = checks + 4;
        if (pc !== 32'h14) begin errors++; $display("FAIL redir_pc: got %h expected 14", pc); end
        if (imem_addr !== 10'd5) begin errors++; $display("FAIL redir_imem_addr: got %h expected 5", imem_addr); end
        if (if_id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", if_id_valid); end
        if (if_id_instr !== 32'h0) begin errors++; $display("FAIL redir_instr: got %h expected 0", if_id_instr); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks = checks + 2;
        if (if_id_valid !== 1'b1) begin errors++; $display("FAIL redir_next_valid: got %b expected 1", if_id_valid); end
        if (if_id_pc4 !== 32'h18) begin errors++; $display("FAIL redir_next_pc4: got %h expected 18", if_id_pc4); end
    endtask

    task automatic test_flush_stall();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checks = checks + 3;
        if (pc !== 32'h10) begin errors++; $display("FAIL flush_stall_pc: got %h expected 10", pc); end
        if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_valid: got %b expected 0", if_id_valid); end
        if (fetch_count !== 32'd4) begin errors++; $display("FAIL flush_stall_count: got %0d expected 4", fetch_count); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks = checks + 3;
        if (pc !== 32'h14) begin errors++; $display("FAIL flush_pc: got %h expected 14", pc); end
        if (if_id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", if_id_valid); end
        if (fetch_count !== 32'd4) begin errors++; $display("FAIL flush_count: got %0d expected 4", fetch_count); end
    endtask

    task automatic test_misaligned();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0016);
        checks = checks + 2;
        if (pc !== 32'h14) begin errors++; $display("FAIL misalign_pc: got %h expected 14", pc); end
        if (addr_err !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", addr_err); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            checks++;
            if (addr_err !== 1'b1) begin errors++; $display("FAIL misalign_sticky: cycle %0d got %b expected 1", i, addr_err); end
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b expected 0", addr_err); end
    endtask

    task automatic test_range();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0FFC);
        checks = checks + 2;
        if (pc !== 32'h0FFC) begin errors++; $display("FAIL range_redir_pc: got %h expected ffc", pc); end
        if (addr_err !== 1'b0) begin errors++; $display("FAIL range_redir_err: got %b expected 0", addr_err); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks = checks + 5;
        if (pc !== 32'h1000) begin errors++; $display("FAIL range_pc: got %h expected 1000", pc); end
        if (imem_addr !== 10'd0) begin errors++; $display("FAIL range_imem_addr: got %h expected 0", imem_addr); end
        if (addr_err !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", addr_err); end
        if (if_id_pc4 !== 32'h1000) begin errors++; $display("FAIL range_pc4: got %h expected 1000", if_id_pc4); end
        if (if_id_instr !== 32'hA500_03FF) begin errors++; $display("FAIL range_instr: got %h expected a50003ff", if_id_instr); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checks = checks + 2;
        if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected 0", pc); end
        if (if_id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected 0", if_id_pc4); end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rpc;
        for (int i = 0; i < 300; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[31:12] = 20'h0;
            if ($urandom_range(0, 1) != 0) rpc[1:0] = 2'b00;
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), rpc);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
        mem[0] = 32'h0022_1820;
        mem[1] = 32'h0022_2022;
        test_reset();
        test_normal();
        test_stall();
        test_redirect();
        test_flush_stall();
        test_misaligned();
        test_range();
        test_back_to_back();
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; rst = 1'b0;
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
